// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the data-memory port shared by dmem_arbiter.
// slave = arbiter side, master = requesters plus memory.
interface dmem_arbiter_if #(
  parameter int F3     = 3,
  parameter int ADDLEN = 32,
  parameter int VLEN   = 32
);
  logic              req0_valid;
  logic              req0_ready;
  logic              req0_write;
  logic [F3-1:0]     req0_funct3;
  logic [ADDLEN-1:0] req0_addr;
  logic [VLEN-1:0]   req0_wdata;
  logic              rsp0_valid;
  logic [VLEN-1:0]   rsp0_rdata;
  logic              rsp0_err;

  logic              req1_valid;
  logic              req1_ready;
  logic              req1_write;
  logic [F3-1:0]     req1_funct3;
  logic [ADDLEN-1:0] req1_addr;
  logic [VLEN-1:0]   req1_wdata;
  logic              rsp1_valid;
  logic [VLEN-1:0]   rsp1_rdata;
  logic              rsp1_err;

  logic [F3-1:0]     mem_funct3;
  logic [ADDLEN-1:0] mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [VLEN-1:0]   mem_wdata;
  logic [VLEN-1:0]   mem_rdata;

  modport slave (
    input  req0_valid, req0_write, req0_funct3, req0_addr, req0_wdata,
    output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
    input  req1_valid, req1_write, req1_funct3, req1_addr, req1_wdata,
    output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
    output mem_funct3, mem_address, mem_read, mem_write, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output req0_valid, req0_write, req0_funct3, req0_addr, req0_wdata,
    input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
    output req1_valid, req1_write, req1_funct3, req1_addr, req1_wdata,
    input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
    input  mem_funct3, mem_address, mem_read, mem_write, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: IDLE -> ACCESS -> RESP, one access in flight.
// Define DMEM_ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin.
module dmem_arbiter #(
  parameter int F3     = 3,
  parameter int ADDLEN = 32,
  parameter int VLEN   = 32,
  parameter int LEN    = 100
) (
  input  logic clk,
  input  logic rst_n,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [ADDLEN:0] LEN_EXT = LEN;
  localparam logic [ADDLEN:0] SZ1 = 1;
  localparam logic [ADDLEN:0] SZ2 = 2;
  localparam logic [ADDLEN:0] SZ4 = 4;

  state_t            state_reg, state_next;
  logic              port_reg, write_reg, err_reg;
  logic [F3-1:0]     funct3_reg;
  logic [ADDLEN-1:0] addr_reg;
  logic [VLEN-1:0]   wdata_reg, rdata_reg;
`ifndef DMEM_ARB_FIXED_PRIO_EN
  logic              last_grant_reg;
`endif

  logic              sel, take;
  logic              sel_write, sel_err;
  logic [F3-1:0]     sel_funct3;
  logic [ADDLEN-1:0] sel_addr;
  logic [VLEN-1:0]   sel_wdata;

  // Sum is one bit wider than the address so addr+size cannot wrap below LEN.
  function automatic logic calc_err(input logic wr, input logic [F3-1:0] f3,
                                    input logic [ADDLEN-1:0] addr);
    logic [ADDLEN:0] size;
    logic illegal, misalign, range;
    case (f3[1:0])
      2'b00:   size = SZ1;
      2'b01:   size = SZ2;
      default: size = SZ4;
    endcase
    if (wr) illegal = (f3 > F3'(2));
    else    illegal = (f3 == F3'(3)) || (f3 == F3'(6)) || (f3 == F3'(7));
    misalign = ((f3[1:0] == 2'b01) && addr[0]) ||
               ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    range = ({1'b0, addr} + size) > LEN_EXT;
    return illegal || misalign || range;
  endfunction

  always_comb begin
    sel = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      sel = 1'b0;
`else
      sel = ~last_grant_reg;
`endif
    end else if (bus.req1_valid) begin
      sel = 1'b1;
    end
    sel_write  = sel ? bus.req1_write  : bus.req0_write;
    sel_funct3 = sel ? bus.req1_funct3 : bus.req0_funct3;
    sel_addr   = sel ? bus.req1_addr   : bus.req0_addr;
    sel_wdata  = sel ? bus.req1_wdata  : bus.req0_wdata;
    sel_err    = calc_err(sel_write, sel_funct3, sel_addr);
  end

  always_comb begin
    state_next     = state_reg;
    take           = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    bus.rsp0_rdata = '0;
    bus.rsp1_rdata = '0;
    bus.rsp0_err   = 1'b0;
    bus.rsp1_err   = 1'b0;
    case (state_reg)
      IDLE: begin
        take           = rst_n && (bus.req0_valid || bus.req1_valid);
        bus.req0_ready = take && !sel;
        bus.req1_ready = take && sel;
        if (take) state_next = ACCESS;
      end
      ACCESS: begin
        bus.mem_read  = !write_reg && !err_reg;
        bus.mem_write = write_reg && !err_reg;
        state_next    = RESP;
      end
      RESP: begin
        bus.rsp0_valid = !port_reg;
        bus.rsp1_valid = port_reg;
        bus.rsp0_rdata = port_reg ? '0 : rdata_reg;
        bus.rsp1_rdata = port_reg ? rdata_reg : '0;
        bus.rsp0_err   = !port_reg && err_reg;
        bus.rsp1_err   = port_reg && err_reg;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.mem_funct3  = funct3_reg;
  assign bus.mem_address = addr_reg;
  assign bus.mem_wdata   = wdata_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      port_reg       <= 1'b0;
      write_reg      <= 1'b0;
      err_reg        <= 1'b0;
      funct3_reg     <= '0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      rdata_reg      <= '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last_grant_reg <= 1'b1;
`endif
    end else begin
      state_reg <= state_next;
      if (take) begin
        port_reg       <= sel;
        write_reg      <= sel_write;
        err_reg        <= sel_err;
        funct3_reg     <= sel_funct3;
        addr_reg       <= sel_addr;
        wdata_reg      <= sel_wdata;
`ifndef DMEM_ARB_FIXED_PRIO_EN
        last_grant_reg <= sel;
`endif
      end
      if (state_reg == ACCESS)
        rdata_reg <= (write_reg || err_reg) ? '0 : bus.mem_rdata;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a little-endian byte memory model.
// Checks reset state, load/store paths, error rules, arbitration and mid-access reset.
module tb_dmem_arbiter;
  localparam int LEN = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  dmem_arbiter_if #(.F3(3), .ADDLEN(32), .VLEN(32)) bus ();

  dmem_arbiter #(.F3(3), .ADDLEN(32), .VLEN(32), .LEN(LEN)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:LEN-1] = '{default: 8'h00};

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    if (a < LEN) return mem[a[6:0]];
    return 8'h00;
  endfunction

  always_comb begin
    logic [7:0] b0, b1, b2, b3;
    b0 = byte_at(bus.mem_address);
    b1 = byte_at(bus.mem_address + 32'd1);
    b2 = byte_at(bus.mem_address + 32'd2);
    b3 = byte_at(bus.mem_address + 32'd3);
    case (bus.mem_funct3)
      3'b000:  bus.mem_rdata = {{24{b0[7]}}, b0};
      3'b001:  bus.mem_rdata = {{16{b1[7]}}, b1, b0};
      3'b010:  bus.mem_rdata = {b3, b2, b1, b0};
      3'b100:  bus.mem_rdata = {24'h0, b0};
      3'b101:  bus.mem_rdata = {16'h0, b1, b0};
      default: bus.mem_rdata = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (bus.mem_write) begin
      for (int k = 0; k < 4; k++) begin
        if ((k == 0 || (k == 1 && bus.mem_funct3[1:0] != 2'b00) || bus.mem_funct3[1:0] == 2'b10)
            && (bus.mem_address + 32'(k) < LEN))
          mem[7'(bus.mem_address + 32'(k))] <= bus.mem_wdata[8*k +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input logic v, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (p == 0) begin
      bus.req0_valid = v; bus.req0_write = wr; bus.req0_funct3 = f3;
      bus.req0_addr = addr; bus.req0_wdata = wd;
    end else begin
      bus.req1_valid = v; bus.req1_write = wr; bus.req1_funct3 = f3;
      bus.req1_addr = addr; bus.req1_wdata = wd;
    end
  endtask

  // Caller is in IDLE, #1 after a rising edge; returns #1 after the edge back into IDLE.
  task automatic access(input string tag, input int p, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err);
    drive(p, 1'b1, wr, f3, addr, wd);
    #1;
    chk({tag, " ready"}, {31'h0, (p == 0) ? bus.req0_ready : bus.req1_ready}, 32'd1);
    @(posedge clk); #1;
    drive(p, 1'b0, wr, f3, addr, wd);
    chk({tag, " mem_read"},  {31'h0, bus.mem_read},  {31'h0, !wr && !exp_err});
    chk({tag, " mem_write"}, {31'h0, bus.mem_write}, {31'h0, wr && !exp_err});
    chk({tag, " mem_address"}, bus.mem_address, addr);
    @(posedge clk); #1;
    chk({tag, " rsp_valid"}, {30'h0, bus.rsp1_valid, bus.rsp0_valid}, (p == 0) ? 32'd1 : 32'd2);
    chk({tag, " rdata"}, (p == 0) ? bus.rsp0_rdata : bus.rsp1_rdata, exp_rd);
    chk({tag, " err"}, {31'h0, (p == 0) ? bus.rsp0_err : bus.rsp1_err}, {31'h0, exp_err});
    @(posedge clk); #1;
    chk({tag, " rsp_drop"}, {30'h0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
  endtask

  initial begin
    int exp_port;
    drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset mem_read",    {31'h0, bus.mem_read},  32'd0);
    chk("reset mem_write",   {31'h0, bus.mem_write}, 32'd0);
    chk("reset mem_address", bus.mem_address, 32'd0);
    chk("reset mem_wdata",   bus.mem_wdata,   32'd0);
    chk("reset mem_funct3",  {29'h0, bus.mem_funct3}, 32'd0);
    chk("reset rsp",         {28'h0, bus.rsp1_valid, bus.rsp0_valid, bus.rsp1_err, bus.rsp0_err}, 32'd0);
    chk("reset ready",       {30'h0, bus.req1_ready, bus.req0_ready}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    access("sw 0x10",        0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    access("lw 0x10",        0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    access("lb 0x10",        1, 1'b0, 3'b000, 32'h10, 32'h0, 32'hFFFFFFEF, 1'b0);
    access("lbu 0x10",       1, 1'b0, 3'b100, 32'h10, 32'h0, 32'h000000EF, 1'b0);
    access("lh 0x12",        1, 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0);
    access("lw 0x12 misal",  0, 1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1);
    access("lhu 0x11 misal", 0, 1'b0, 3'b101, 32'h11, 32'h0, 32'h0, 1'b1);
    access("sw 0x60 edge",   1, 1'b1, 3'b010, 32'h60, 32'hCAFEF00D, 32'h0, 1'b0);
    access("sw 0x62 range",  1, 1'b1, 3'b010, 32'h62, 32'h11111111, 32'h0, 1'b1);
    access("lw 0x60",        0, 1'b0, 3'b010, 32'h60, 32'h0, 32'hCAFEF00D, 1'b0);
    access("lbu 0x63 edge",  0, 1'b0, 3'b100, 32'h63, 32'h0, 32'h000000CA, 1'b0);
    access("lw wrap",        1, 1'b0, 3'b010, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b1);
    access("load f3=011",    0, 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
    access("store f3=100",   1, 1'b1, 3'b100, 32'h10, 32'h55, 32'h0, 1'b1);
    access("lw 0x10 intact", 1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // Reset in the middle of a store's ACCESS cycle.
    drive(1, 1'b1, 1'b1, 3'b010, 32'h20, 32'h12345678);
    #1;
    chk("rst sw ready1", {31'h0, bus.req1_ready}, 32'd1);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b1, 3'b010, 32'h20, 32'h12345678);
    chk("rst sw strobe", {31'h0, bus.mem_write}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst strobe drop", {31'h0, bus.mem_write}, 32'd0);
    chk("rst address",     bus.mem_address, 32'd0);
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    chk("rst byte 0x20", {24'h0, mem[7'h20]}, 32'd0);

    // Both ports continuously valid: six grants.
    drive(0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    drive(1, 1'b1, 1'b0, 3'b100, 32'h10, 32'h0);
    for (int i = 0; i < 6; i++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      exp_port = 0;
`else
      exp_port = i % 2;
`endif
      #1;
      chk($sformatf("rr%0d ready", i), {30'h0, bus.req1_ready, bus.req0_ready},
          (exp_port == 0) ? 32'd1 : 32'd2);
      @(posedge clk); #1;
      chk($sformatf("rr%0d mem_read", i), {31'h0, bus.mem_read}, 32'd1);
      @(posedge clk); #1;
      chk($sformatf("rr%0d rsp_valid", i), {30'h0, bus.rsp1_valid, bus.rsp0_valid},
          (exp_port == 0) ? 32'd1 : 32'd2);
      chk($sformatf("rr%0d rdata", i),
          (exp_port == 0) ? bus.rsp0_rdata : bus.rsp1_rdata,
          (exp_port == 0) ? 32'hDEADBEEF : 32'h000000EF);
      @(posedge clk);
    end
    drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester controller that shares the single byte-addressed data memory between the core load/store unit (port 0) and the DMA/loader engine (port 1).
- Arbitrates between requests, registers the winning request, and drives the memory's funct3, address, read-strobe and write-strobe inputs for exactly one cycle.
- Captures the memory's combinational read data and returns a registered response with an error flag.
- Sits between the pipeline MEM stage / DMA engine and the data memory.

Parameters:
F3, 3, width of funct3 field
ADDLEN, 32, address width
VLEN, 32, data width
LEN, 100, memory depth in bytes; used for the bounds check

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  port 0 request present
req0_ready  out  1  port 0 request accepted this cycle
req0_write  in  1  1=store, 0=load
req0_funct3  in  F3  RISC-V load/store width code
req0_addr  in  ADDLEN  byte address
req0_wdata  in  VLEN  store data, low bytes used
rsp0_valid  out  1  one-cycle response pulse
rsp0_rdata  out  VLEN  load result, 0 for stores and errors
rsp0_err  out  1  request rejected (misaligned, out of range, illegal funct3)
req1_valid, req1_ready, req1_write, req1_funct3, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata, rsp1_err  same as port 0, for port 1
mem_funct3  out  F3  to memory funct3
mem_address  out  ADDLEN  to memory address
mem_read  out  1  to memory read strobe
mem_write  out  1  to memory write strobe
mem_wdata  out  VLEN  to memory store data
mem_rdata  in  VLEN  from memory read data, combinational from mem_address

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all req*_ready, rsp*_valid, rsp*_err, mem_read and mem_write = 0.
  - rsp*_rdata, mem_address, mem_wdata and mem_funct3 = 0.
  - last_grant=1, so port 0 wins first.
  - Reset mid-access aborts the access; no write strobe survives the reset edge.
- FSM IDLE -> ACCESS -> RESP -> IDLE. One request is in flight at a time.
- IDLE:
  - req*_ready is combinational and asserted only for the grant winner.
  - Both valid: round-robin, the port not equal to last_grant wins.
  - One valid: that port wins.
  - On handshake (valid & ready), latch port id, write, funct3, addr, wdata and the computed error; update last_grant; go to ACCESS.
- ACCESS (one cycle):
  - mem_funct3, mem_address and mem_wdata are driven from the latched registers.
  - mem_read = !write & !err; mem_write = write & !err.
  - Load data: mem_rdata is captured into the response register at the end of the cycle.
  - Go to RESP.
- RESP (one cycle):
  - rspN_valid=1 for the latched port only.
  - rspN_rdata = captured data, or 0 for stores or errors; rspN_err = latched error.
  - Go to IDLE. A new grant is possible in the next cycle.
- Latency: handshake at edge T, memory strobe during cycle T+1, rsp_valid during cycle T+2. Peak throughput is 1 access per 3 cycles.
- Error rules, evaluated at accept time. Size is 1, 2 or 4 bytes from funct3[1:0].
  - Illegal funct3: loads with 011/110/111; stores with funct3 > 010.
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
  - Out of range: addr + size > LEN, computed at ADDLEN+1 bits so that the sum cannot wrap.
  - On error, no memory strobe fires; the response is still delivered with the normal latency.
- Outside ACCESS, mem_read and mem_write = 0; address, data and funct3 hold their last values.
- Requesters hold valid and fields stable until ready. Deasserting valid before ready is allowed; the request is simply not taken.

Optional Feature:
- Macro: DMEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, port 0 always wins a simultaneous request; last_grant is unused.
- Undefined: round-robin as specified above.

Test Plan:
- Port 0 store sw addr 0x10 data 0xDEADBEEF, then lw addr 0x10 -> mem_write for one cycle at T+1; load gets rsp0_valid at T+2 with rdata=0xDEADBEEF, err=0.
- Port 1 lb addr 0x10 after that store -> rsp1_rdata=0xFFFFFFEF; lbu -> 0x000000EF.
- Both ports valid for 6 consecutive accesses -> grants alternate 0,1,0,1,0,1. With DMEM_ARB_FIXED_PRIO_EN, all 6 grants go to port 0 while it stays valid.
- lw addr 0x12 (misaligned) and sw addr 0x62 (LEN=100, out of range) -> no mem_read/mem_write pulse; rsp_err=1, rdata=0, latency 2 cycles.
- Load funct3=011 and store funct3=100 -> err=1, no strobe.
- rst_n low during ACCESS of sw addr 0x20 -> mem_write drops immediately; byte 0x20 unchanged; FSM is in IDLE when reset releases; the first grant goes to port 0.
